// File: rtl/pwm_generator_if.sv
// Register-file side bundle for pwm_generator: enables, mode selects and duty in,
// pin drives and period marker out.
interface pwm_generator_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] out_7_0;
  logic [7:0] out_15_8;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out_7_0, out_15_8, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out_7_0, out_15_8, period_start
  );
endinterface

// File: rtl/pwm_generator.sv
// 16-pin output driver: each pin forced low, forced high, or following one shared
// 8-bit PWM waveform built from a prescaled counter with a double-buffered duty.
module pwm_generator #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_generator_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] prescCnt_q, prescCnt_d;
  logic [7:0]    pwmCnt_q, pwmCnt_d;
  logic [7:0]    dutyAct_q, dutyAct_d;
  logic          periodStart_q, periodStart_d;
  logic [15:0]   out_q, out_d;

  logic        tick;
  logic        wrap;
  logic        pwmLevel;
  logic [15:0] enOut;
  logic [15:0] enPwm;

  assign enOut = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign enPwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  assign tick = (prescCnt_q == PW'(PRESCALE - 1));
  assign wrap = tick && (pwmCnt_q == 8'hFF);

  // Full scale is special-cased so 0xFF stays high through count 0xFF too.
  assign pwmLevel = (dutyAct_q == 8'hFF) ? 1'b1 : (pwmCnt_q < dutyAct_q);

  always_comb begin
    prescCnt_d    = tick ? '0 : prescCnt_q + PW'(1);
    pwmCnt_d      = tick ? pwmCnt_q + 8'd1 : pwmCnt_q;
    dutyAct_d     = wrap ? bus.pwm_duty_cycle : dutyAct_q;
    periodStart_d = wrap;
    out_d         = enOut & (~enPwm | {16{pwmLevel}});
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prescCnt_q    <= '0;
      pwmCnt_q      <= '0;
      dutyAct_q     <= '0;
      periodStart_q <= 1'b0;
      out_q         <= '0;
    end else begin
      prescCnt_q    <= prescCnt_d;
      pwmCnt_q      <= pwmCnt_d;
      dutyAct_q     <= dutyAct_d;
      periodStart_q <= periodStart_d;
      out_q         <= out_d;
    end
  end

  assign bus.out_7_0      = out_q[7:0];
  assign bus.out_15_8     = out_q[15:8];
  assign bus.period_start = periodStart_q;

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Consumes the SPI register-file outputs and drives the 16 output pins.
- Each pin is either forced low, forced high, or driven by a shared 8-bit PWM waveform.
- The waveform is derived from a prescaled free-running counter.
- Duty cycle is double-buffered so SPI writes never glitch a period in progress.

Parameters:
PRESCALE, 13, clk cycles per PWM count tick (>=1); 256 ticks per period; 13 gives ~3.0 kHz at 10 MHz clk.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-high reset (asserted when rst_n=1)
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0
en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8
pwm_duty_cycle  input  8  requested duty, 0x00=0%, 0xFF=100%
out_7_0  output  8  registered pin drive, pins 7..0
out_15_8  output  8  registered pin drive, pins 15..8
period_start  output  1  one-clk pulse on the first clk of each PWM period

Behaviour:
- Reset (rst_n=1, async) clears all state at once, including mid-period:
  - presc_cnt=0, pwm_cnt=0, duty_act=0
  - out_7_0=0, out_15_8=0, period_start=0
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick=1 when presc_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick every clk.
- PWM counter:
  - 8-bit pwm_cnt increments on tick.
  - 0xFF wraps to 0x00 (wrap = tick && pwm_cnt==0xFF).
- Duty shadow:
  - duty_act loads pwm_duty_cycle on wrap only.
  - Changes to pwm_duty_cycle mid-period are ignored until the next wrap.
  - If several writes land in one period, the last value before wrap wins.
- After reset, the first period uses duty_act=0.
  - A new duty appears starting with the second period, i.e. after the first wrap.
- period_start:
  - Registered; asserted for exactly one clk, the clk after wrap.
  - At that point pwm_cnt==0 and duty_act holds the new value.
  - Not asserted out of reset.
- pwm_level, combinational from current state:
  - duty_act==0xFF: 1
  - otherwise: (pwm_cnt < duty_act)
  - Result: 0x00 is constant 0, 0xFF is constant 1, 0x80 is high for 128 of 256 ticks.
- Per pin i (0..15), registered:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0
- Latencies and timing:
  - Enable and mode changes are unbuffered: visible on out one clk after the input changes.
  - Output is one clk behind the counter state.
  - A 1-pin-wide waveform edge moves by at most one clk relative to the tick.
- Period length is exactly 256*PRESCALE clks.
  - High time is duty_act*PRESCALE clks for duty_act<0xFF.
- Boundary cases:
  - en_out=0 overrides en_pwm=1 (pin low).
  - en_pwm=1 with en_out=1 and duty 0 gives a pin that stays low.
  - Simultaneous wrap and duty write: the value present on that clk is captured.
- No handshakes. Inputs are treated as stable synchronous register outputs in the clk domain.

Test Plan:
- Reset then release, all enables 0, duty 0x80 -> out_7_0=out_15_8=0x00 for 3 full periods; period_start pulses every 256*PRESCALE clks.
- en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0x00 -> out_7_0=0xFF one clk after the enable write; out_15_8 stays 0x00.
- PRESCALE=1, en_out_15_8=0x01, en_pwm_15_8=0x01, duty 0x40:
  - from the second period, pin 8 is high exactly 64 clks then low 192 clks per 256-clk period;
  - first period after reset is all low.
- Duty 0x00 and 0xFF on a PWM pin -> constant 0 and constant 1 across 2 periods, no single-clk glitch at wrap.
- Change duty 0x40->0xC0 at pwm_cnt=0x50 -> current period finishes at 64 high clks; next period (after period_start) is 192 high clks.
- Assert rst_n=1 mid-period with outputs high -> outputs 0x0000 immediately (before the next clk edge); on release, counters restart from 0 and duty_act=0.
